// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_HOLD  = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

  localparam int          DEF_FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_PC         = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// EX-side requests into the controller and the redirect/hold/flush fan-out it drives.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
);
  logic [ADDR_W-1:0] jump_addr2ctrl;
  logic              jump_en2ctrl;
  logic              hold2ctrl;
  logic              mem_busy;
  logic [ADDR_W-1:0] jump_addr2pc;
  logic              jump_en2pc;
  logic              hold2pc;
  logic              hold2if_id;
  logic              hold2id_ex;
  logic              flush2if_id;
  logic              flush2id_ex;
  logic              ctrl_err;
  logic [PERF_W-1:0] redirect_cnt;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output jump_addr2ctrl, jump_en2ctrl, hold2ctrl, mem_busy,
    input  jump_addr2pc, jump_en2pc, hold2pc, hold2if_id, hold2id_ex,
           flush2if_id, flush2id_ex, ctrl_err, redirect_cnt, stall_cnt
  );

  modport slave (
    input  jump_addr2ctrl, jump_en2ctrl, hold2ctrl, mem_busy,
    output jump_addr2pc, jump_en2pc, hold2pc, hold2if_id, hold2id_ex,
           flush2if_id, flush2id_ex, ctrl_err, redirect_cnt, stall_cnt
  );
endinterface

// File: rtl/ctrl_perf_cnt.sv
// Free-running enable counter with synchronous reset; wraps modulo 2^PERF_W.
module ctrl_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PERF_W-1:0] cnt
);
  logic [PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Redirect/hold/flush controller between EX and pc_reg/if_id/id_ex.
// Optional perf counters enabled by defining CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int PERF_W       = 32
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  ctrl_state_e       state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctrl_err_q, ctrl_err_d;
  logic              hold_any;
  logic              issue;
  logic              flush;
  logic [ADDR_W-1:0] issue_addr;

  assign hold_any = bus.hold2ctrl | bus.mem_busy;

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    ctrl_err_d  = ctrl_err_q;
    issue       = 1'b0;
    issue_addr  = '0;
    flush       = 1'b0;

    case (state_q)
      CTRL_RUN: begin
        if (bus.jump_en2ctrl && !hold_any) begin
          issue      = 1'b1;
          issue_addr = bus.jump_addr2ctrl;
        end else if (bus.jump_en2ctrl) begin
          pend_addr_d = bus.jump_addr2ctrl;
          pend_vld_d  = 1'b1;
          state_d     = CTRL_HOLD;
        end else if (hold_any) begin
          state_d = CTRL_HOLD;
        end
      end
      CTRL_HOLD: begin
        if (hold_any) begin
          // The stalled EX keeps presenting its jump; the latest value wins.
          if (bus.jump_en2ctrl) begin
            pend_addr_d = bus.jump_addr2ctrl;
            pend_vld_d  = 1'b1;
          end
        end else if (pend_vld_q) begin
          issue      = 1'b1;
          issue_addr = pend_addr_q;
          pend_vld_d = 1'b0;
        end else if (bus.jump_en2ctrl) begin
          issue      = 1'b1;
          issue_addr = bus.jump_addr2ctrl;
        end else begin
          state_d = CTRL_RUN;
        end
      end
      CTRL_FLUSH: begin
        flush = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // EX holds a bubble here, so any redirect request is a protocol error.
        if (bus.jump_en2ctrl) ctrl_err_d = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = hold_any ? CTRL_HOLD : CTRL_RUN;
      end
      default: state_d = CTRL_RUN;
    endcase

    if (issue) begin
      flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = CTRL_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = CTRL_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= ADDR_W'(RESET_PC);
      cnt_q       <= '0;
      ctrl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
      ctrl_err_q  <= ctrl_err_d;
    end
  end

  assign bus.hold2pc      = hold_any & ~rst;
  assign bus.hold2if_id   = hold_any & ~rst;
  assign bus.hold2id_ex   = hold_any & ~rst;
  assign bus.jump_en2pc   = issue & ~rst;
  assign bus.jump_addr2pc = (issue && !rst) ? issue_addr : '0;
  assign bus.flush2if_id  = flush & ~rst;
  assign bus.flush2id_ex  = flush & ~rst;
  assign bus.ctrl_err     = ctrl_err_q & ~rst;

`ifdef CTRL_PERF_EN
  logic [PERF_W-1:0] redirect_raw, stall_raw;

  ctrl_perf_cnt #(.PERF_W(PERF_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .en  (issue),
    .cnt (redirect_raw)
  );

  ctrl_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold_any),
    .cnt (stall_raw)
  );

  assign bus.redirect_cnt = rst ? '0 : redirect_raw;
  assign bus.stall_cnt    = rst ? '0 : stall_raw;
`else
  assign bus.redirect_cnt = '0;
  assign bus.stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected redirects queued at stimulus, popped on jump_en2pc.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int PERF_W       = 32;
  localparam int FLUSH_CYCLES = 2;
`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) bus ();

  pipeline_ctrl #(
    .ADDR_W       (ADDR_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PERF_W       (PERF_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  int          exp_stall = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic je, input logic [31:0] a,
                       input logic h, input logic mb);
    rst                = r;
    bus.jump_en2ctrl   = je;
    bus.jump_addr2ctrl = a;
    bus.hold2ctrl      = h;
    bus.mem_busy       = mb;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    if (rst) exp_stall = 0;
    else if (bus.hold2ctrl || bus.mem_busy) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic je, input logic [1:0] fl,
                         input logic [2:0] hd);
    chk({tag, "_jump_en"}, 32'(bus.jump_en2pc), 32'(je));
    chk({tag, "_flush"}, 32'({bus.flush2if_id, bus.flush2id_ex}), 32'(fl));
    chk({tag, "_hold"}, 32'({bus.hold2pc, bus.hold2if_id, bus.hold2id_ex}), 32'(hd));
  endtask

  task automatic chk_rst_zero(input string tag);
    chk(tag, 32'(|{bus.jump_addr2pc, bus.jump_en2pc, bus.hold2pc, bus.hold2if_id,
                   bus.hold2id_ex, bus.flush2if_id, bus.flush2id_ex, bus.ctrl_err,
                   bus.redirect_cnt, bus.stall_cnt}), 32'(0));
  endtask

  // Redirect monitor: every strobe must match the oldest expected target.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.jump_en2pc === 1'b1) begin
        if (sb_q.size() == 0) chk("sb_spurious", 32'(bus.jump_en2pc), 32'(0));
        else chk("sb_addr", bus.jump_addr2pc, sb_q.pop_front());
      end
    end
  end

  initial begin
    // Reset held with a live jump request
    drive(1, 1, 32'h55, 0, 0);
    repeat (3) begin
      smp(); chk_rst_zero("t1_rst_zero"); next_cyc();
    end
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t1_idle", 0, 2'b00, 3'b000);
    chk("t1_err", 32'(bus.ctrl_err), 32'(0));
    next_cyc();

    // Plain redirect, two flush cycles
    sb_q.push_back(32'h100);
    drive(0, 1, 32'h100, 0, 0);
    smp(); chk_out("t2_issue", 1, 2'b11, 3'b000); next_cyc();
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t2_flush", 0, 2'b11, 3'b000); next_cyc();
    smp(); chk_out("t2_done", 0, 2'b00, 3'b000);
    chk("t2_err", 32'(bus.ctrl_err), 32'(0));
    next_cyc();

    // Jump request during FLUSH is ignored and flagged
    sb_q.push_back(32'h180);
    drive(0, 1, 32'h180, 0, 0);
    smp(); chk_out("t5_issue", 1, 2'b11, 3'b000); next_cyc();
    drive(0, 1, 32'hBAD, 0, 0);
    smp(); chk_out("t5_flush", 0, 2'b11, 3'b000); next_cyc();
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t5_done", 0, 2'b00, 3'b000);
    chk("t5_err", 32'(bus.ctrl_err), 32'(1));
    next_cyc();

    // Jump held behind mem_busy, replayed on release
    drive(0, 1, 32'h200, 0, 1);
    repeat (4) begin
      smp(); chk_out("t3_hold", 0, 2'b00, 3'b111); next_cyc();
    end
    sb_q.push_back(32'h200);
    drive(0, 1, 32'h200, 0, 0);
    smp(); chk_out("t3_replay", 1, 2'b11, 3'b000); next_cyc();
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t3_flush", 0, 2'b11, 3'b000); next_cyc();
    smp(); chk_out("t3_done", 0, 2'b00, 3'b000); next_cyc();

    // Last held address wins; live address on release is not used
    drive(0, 1, 32'h300, 1, 0);
    smp(); chk_out("t3b_hold0", 0, 2'b00, 3'b111); next_cyc();
    drive(0, 1, 32'h340, 1, 0);
    smp(); chk_out("t3b_hold1", 0, 2'b00, 3'b111); next_cyc();
    sb_q.push_back(32'h340);
    drive(0, 1, 32'h3FF, 0, 0);
    smp(); chk_out("t3b_replay", 1, 2'b11, 3'b000); next_cyc();
    drive(0, 0, 0, 0, 0);
    next_cyc();
    smp(); chk_out("t3b_done", 0, 2'b00, 3'b000); next_cyc();

    // EX stall alone
    drive(0, 0, 0, 1, 0);
    repeat (3) begin
      smp(); chk_out("t4_hold", 0, 2'b00, 3'b111); next_cyc();
    end
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t4_run", 0, 2'b00, 3'b000);
    chk("t4_err_sticky", 32'(bus.ctrl_err), 32'(1));
    chk("t4_stall_cnt", bus.stall_cnt, PERF ? 32'(exp_stall) : 32'(0));
    chk("t4_redirect_cnt", bus.redirect_cnt, PERF ? 32'(4) : 32'(0));
    next_cyc();

    // Hold arriving during FLUSH: flush runs out, then HOLD, then RUN with no replay
    sb_q.push_back(32'h700);
    drive(0, 1, 32'h700, 0, 0);
    smp(); chk_out("t7_issue", 1, 2'b11, 3'b000); next_cyc();
    drive(0, 0, 0, 1, 0);
    smp(); chk_out("t7_flush_hold", 0, 2'b11, 3'b111); next_cyc();
    smp(); chk_out("t7_hold", 0, 2'b00, 3'b111); next_cyc();
    drive(0, 0, 0, 0, 0);
    smp(); chk_out("t7_run", 0, 2'b00, 3'b000); next_cyc();

    // Reset while a jump is pending in HOLD
    drive(0, 1, 32'h600, 0, 1);
    smp(); chk_out("t6_hold", 0, 2'b00, 3'b111); next_cyc();
    next_cyc();
    drive(1, 0, 0, 0, 0);
    smp(); chk_rst_zero("t6_rst_zero"); next_cyc();
    drive(0, 0, 0, 0, 0);
    repeat (3) begin
      smp(); chk_out("t6_no_replay", 0, 2'b00, 3'b000); next_cyc();
    end
    smp();
    chk("t6_err_cleared", 32'(bus.ctrl_err), 32'(0));
    chk("t6_redirect_cnt", bus.redirect_cnt, 32'(0));
    chk("t6_stall_cnt", bus.stall_cnt, PERF ? 32'(exp_stall) : 32'(0));
    next_cyc();

    next_cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
